// File: rtl/cpu_pkg.sv
// Shared definitions for the RV64 core: architectural width, ebreak encoding,
// fetch sequencer state type and the default boot address.
package cpu_pkg;

    localparam int XLEN = 64;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT,
        FAULT
    } state_t;

    // Instructions are 32-bit, so any PC with nonzero low bits is unusable.
    function automatic logic pc_aligned(input logic [XLEN-1:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/fetch_watchdog.sv
// Counts consecutive unanswered fetch cycles; expired is high during the cycle
// in which one more miss would make TIMEOUT misses in a row.
module fetch_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_reg;

    // Saturating: the sequencer leaves FETCH as soon as expired is seen.
    assign expired = (count_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (enable && !expired) begin
            count_reg <= count_reg + CW'(1);
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Multi-cycle fetch/execute controller: owns the PC, fetches over req/ack,
// issues one execute strobe per instruction, halts on ebreak, faults sticky.
module fetch_sequencer
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int              TIMEOUT  = 16
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic [31:0]     inst,
    output logic            exec_en,
    input  logic            stall,
    input  logic            br_taken,
    input  logic [XLEN-1:0] br_target,
    output logic [XLEN-1:0] pc,
    output logic            halt,
    output logic            fault,
    output logic [XLEN-1:0] retired
);

    state_t          state_reg;
    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] retired_reg;
    logic [31:0]     inst_reg;
    logic            halt_reg;
    logic            fault_reg;
    logic [XLEN-1:0] pc_next;
    logic            wd_expired;

    assign pc_next = br_taken ? br_target : pc_reg + XLEN'(4);

    fetch_watchdog #(
        .TIMEOUT(TIMEOUT)
    ) u_watchdog (
        .clk    (clk),
        .rst    (rst),
        .clear  ((state_reg != FETCH) || imem_ack),
        .enable (state_reg == FETCH),
        .expired(wd_expired)
    );

    // exec_en is the only output with a combinational path from an input.
    assign imem_req  = (state_reg == FETCH);
    assign imem_addr = pc_reg;
    assign exec_en   = (state_reg == EXEC) && !stall;
    assign pc        = pc_reg;
    assign inst      = inst_reg;
    assign retired   = retired_reg;
    assign halt      = halt_reg;
    assign fault     = fault_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            pc_reg      <= RESET_PC;
            inst_reg    <= '0;
            retired_reg <= '0;
            halt_reg    <= 1'b0;
            fault_reg   <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: state_reg <= FETCH;
                FETCH: begin
                    // An ack arriving on the expiry cycle still wins.
                    if (imem_ack) begin
                        inst_reg  <= imem_rdata;
                        state_reg <= EXEC;
                    end else if (wd_expired) begin
                        fault_reg <= 1'b1;
                        state_reg <= FAULT;
                    end
                end
                EXEC: begin
                    if (!stall) begin
                        retired_reg <= retired_reg + XLEN'(1);
                        if (inst_reg == EBREAK) begin
                            halt_reg  <= 1'b1;
                            state_reg <= HALT;
                        end else if (!pc_aligned(pc_next)) begin
                            fault_reg <= 1'b1;
                            state_reg <= FAULT;
                        end else begin
                            pc_reg    <= pc_next;
                            state_reg <= FETCH;
                        end
                    end
                end
                default: state_reg <= state_reg;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed test-plan scenarios plus random traffic,
// every cycle compared against a transaction-level model of the sequencer.
module tb_fetch_sequencer;

    localparam logic [63:0] RPC   = 64'h0000_0000_8000_0000;
    localparam int          TO    = 16;
    localparam logic [31:0] EBRK  = 32'h0010_0073;
    localparam logic [31:0] ADDI  = 32'h0010_0093;
    localparam logic [31:0] ADDI2 = 32'h0020_8113;
    localparam logic [31:0] BEQ   = 32'h0000_0063;

    localparam int M_BOOT = 0, M_WAIT = 1, M_HOLD = 2, M_HALTED = 3, M_FAULTED = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] inst;
    logic        exec_en;
    logic        stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;
    logic [63:0] pc;
    logic        halt;
    logic        fault;
    logic [63:0] retired;

    fetch_sequencer #(
        .RESET_PC(RPC),
        .TIMEOUT (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_rdata(imem_rdata),
        .inst      (inst),
        .exec_en   (exec_en),
        .stall     (stall),
        .br_taken  (br_taken),
        .br_target (br_target),
        .pc        (pc),
        .halt      (halt),
        .fault     (fault),
        .retired   (retired)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: what the core is doing, where it is, what it has retired.
    int          m_mode = M_BOOT;
    bit          m_valid = 1'b0;
    logic [63:0] m_pc;
    logic [63:0] m_retired;
    logic [31:0] m_inst;
    int          m_waited;

    int cyc_n = 0;
    int exec_cnt = 0;
    int first_exec = -1;
    int last_exec = -1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    task automatic compare_outputs();
        check("imem_req", 64'(imem_req), 64'(m_mode == M_WAIT));
        check("imem_addr", imem_addr, m_pc);
        check("exec_en", 64'(exec_en), 64'(m_mode == M_HOLD && !stall));
        check("pc", pc, m_pc);
        check("inst", 64'(inst), 64'(m_inst));
        check("halt", 64'(halt), 64'(m_mode == M_HALTED));
        check("fault", 64'(fault), 64'(m_mode == M_FAULTED));
        check("retired", retired, m_retired);
    endtask

    task automatic model_step();
        logic [63:0] nxt;
        if (!rst) begin
            m_valid   = 1'b1;
            m_mode    = M_BOOT;
            m_pc      = RPC;
            m_inst    = '0;
            m_retired = '0;
            m_waited  = 0;
        end else if (m_valid) begin
            case (m_mode)
                M_BOOT: m_mode = M_WAIT;
                M_WAIT: begin
                    if (imem_ack) begin
                        m_inst   = imem_rdata;
                        m_waited = 0;
                        m_mode   = M_HOLD;
                    end else begin
                        m_waited++;
                        if (m_waited == TO) m_mode = M_FAULTED;
                    end
                end
                M_HOLD: begin
                    if (!stall) begin
                        m_retired = m_retired + 1;
                        nxt = br_taken ? br_target : m_pc + 4;
                        if (m_inst == EBRK) m_mode = M_HALTED;
                        else if (nxt % 4 != 0) m_mode = M_FAULTED;
                        else begin
                            m_pc   = nxt;
                            m_mode = M_WAIT;
                        end
                    end
                end
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive on negedge, compare, then advance model on posedge.
    task automatic cyc(input logic r, input logic a, input logic s, input logic bt,
                       input logic [63:0] tgt, input logic [31:0] rd);
        @(negedge clk);
        rst        = r;
        imem_ack   = a;
        stall      = s;
        br_taken   = bt;
        br_target  = tgt;
        imem_rdata = rd;
        #1;
        if (m_valid) begin
            compare_outputs();
            if (exec_en === 1'b1) begin
                exec_cnt++;
                if (first_exec < 0) first_exec = cyc_n;
                last_exec = cyc_n;
            end
        end
        @(posedge clk);
        model_step();
        cyc_n++;
    endtask

    task automatic reset_and_boot();
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [31:0] words [3];
        logic        r, a, s, bt;
        logic [63:0] tgt;
        logic [31:0] rd;
        words[0] = ADDI;
        words[1] = ADDI2;
        words[2] = EBRK;

        // Zero-wait addi, addi, ebreak.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
        #2;
        check("reset_pc", pc, 64'h8000_0000);
        check("reset_retired", retired, 64'd0);
        check("reset_req", 64'(imem_req), 64'd0);
        check("reset_inst", 64'(inst), 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        exec_cnt = 0;
        first_exec = -1;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, words[i]);
            #2;
            check("zw_addr", imem_addr, 64'h8000_0000 + 64'(4 * i));
            cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        end
        #2;
        check("zw_halt", 64'(halt), 64'd1);
        check("zw_retired", retired, 64'd3);
        check("zw_pc", pc, 64'h8000_0008);
        check("zw_exec_cnt", 64'(exec_cnt), 64'd3);
        check("zw_exec_span", 64'(last_exec - first_exec), 64'd4);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, ADDI);

        // Reset after HALT, delayed ack, stalled execution.
        reset_and_boot();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, $urandom);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, ADDI);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, '0, '0);
        #2;
        check("stall_retired", retired, 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        #2;
        check("delay_retired", retired, 64'd1);

        // Taken branch, then a misaligned branch target.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, BEQ);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0100, '0);
        #2;
        check("br_pc", pc, 64'h8000_0100);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, BEQ);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 64'h8000_0102, '0);
        #2;
        check("mis_fault", 64'(fault), 64'd1);
        check("mis_pc", pc, 64'h8000_0100);
        check("mis_retired", retired, 64'd3);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, ADDI);

        // Fetch timeout: sixteen misses fault, an ack on the sixteenth does not.
        reset_and_boot();
        for (int i = 0; i < TO - 1; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        #2;
        check("to_early_fault", 64'(fault), 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        #2;
        check("to_fault", 64'(fault), 64'd1);
        reset_and_boot();
        for (int i = 0; i < TO - 1; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, ADDI);
        #2;
        check("to_ack_fault", 64'(fault), 64'd0);
        check("to_ack_inst", 64'(inst), 64'(ADDI));
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

        // Reset in the middle of FETCH, with an ack that must not be latched.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, '0, ADDI2);
        #2;
        check("mid_inst", 64'(inst), 64'd0);
        check("mid_req", 64'(imem_req), 64'd0);
        check("mid_pc", pc, 64'h8000_0000);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

        // PC wrap at the top of the address space.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, BEQ);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, '0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, '0, ADDI);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
        #2;
        check("wrap_pc", pc, 64'd0);
        check("wrap_fault", 64'(fault), 64'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            r   = !((m_mode == M_HALTED || m_mode == M_FAULTED) ?
                    ($urandom_range(0, 3) == 0) : ($urandom_range(0, 299) == 0));
            a   = ($urandom_range(0, 9) < 4);
            s   = ($urandom_range(0, 9) < 3);
            bt  = ($urandom_range(0, 9) < 3);
            tgt = {$urandom, $urandom};
            if ($urandom_range(0, 15) != 0) tgt[1:0] = 2'b00;
            rd  = ($urandom_range(0, 29) == 0) ? EBRK : $urandom;
            cyc(r, a, s, bt, tgt, rd);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Multi-cycle fetch/execute controller for the RV64 core. It owns the PC and fetches instructions from instruction memory over a req/ack handshake. It latches each fetched word, gives the single-cycle decode/ALU/regfile datapath exactly one execute-enable pulse per instruction, and advances the PC. It halts on `ebreak` and faults on fetch timeout or a misaligned next PC; both conditions are sticky.

## Interface
Parameters:
- RESET_PC, 64'h80000000, PC value loaded at reset.
- TIMEOUT, 16, maximum FETCH cycles without ack before fault (≥1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; synchronous, active-low (sampled low at posedge resets all state).
- imem_req  out  1  fetch request.
- imem_addr  out  64  fetch address; equals pc.
- imem_ack  in  1  memory accepts request and returns data this cycle.
- imem_rdata  in  32  instruction word, valid when imem_ack=1.
- inst  out  32  latched instruction driven to the datapath.
- exec_en  out  1  one-cycle execute strobe; gates RegWrite/MemWrite in the datapath.
- stall  in  1  datapath not ready; defers execution.
- br_taken  in  1  branch/jump taken for current inst (sampled when exec_en=1).
- br_target  in  64  next PC when br_taken=1.
- pc  out  64  PC of the instruction in flight.
- halt  out  1  ebreak retired; sticky.
- fault  out  1  fetch timeout or misaligned target; sticky.
- retired  out  64  count of retired instructions.

## Operation
- States: IDLE, FETCH, EXEC, HALT, FAULT.
- IDLE: entered on reset. Moves to FETCH on the next cycle unconditionally.
- FETCH: imem_req=1 and imem_addr=pc, both held stable until ack.
  - imem_req & imem_ack: inst <= imem_rdata, timeout counter cleared, go to EXEC.
  - No ack: counter increments. When it reaches TIMEOUT, go to FAULT.
  - Ack in the same cycle as expiry: ack wins.
- EXEC with stall=1: exec_en=0; stay in EXEC; inst and pc held.
- EXEC with stall=0: exec_en=1 for this cycle; retired += 1.
  - inst == 32'h00100073 (ebreak): go to HALT; pc unchanged.
  - Otherwise compute next = br_taken ? br_target : pc + 4 (mod 2^64; wraps from 64'hFFFF_FFFF_FFFF_FFFC to 0).
  - next[1:0] != 0: go to FAULT; pc unchanged. The instruction still counts as retired.
  - Else pc <= next; go to FETCH.
- HALT / FAULT: terminal until reset. imem_req=0, exec_en=0, halt or fault =1 respectively.
- imem_ack outside FETCH is ignored.
- retired wraps at 2^64.

## Timing
- Values during and after reset: pc=RESET_PC, inst=0, imem_req=0, exec_en=0, halt=0, fault=0, retired=0, counter=0, state=IDLE.
- Reset mid-operation: an in-flight request drops in the cycle following the reset edge. Nothing is latched.
- Zero-wait memory: IDLE(1) then FETCH/EXEC alternating, so 2 cycles per instruction. Each wait cycle or stall cycle adds 1.
- Control outputs are Moore, decoded from registered state:
  - imem_req is high in FETCH.
  - exec_en is high in EXEC & !stall. This is the single combinational path from an input.
- pc, inst, retired, halt and fault are registered. Each updates on the edge that ends the corresponding cycle.
- halt or fault rises the cycle after the deciding EXEC/FETCH cycle.

## Structure
- Shared package cpu_pkg holds:
  - state enum (IDLE/FETCH/EXEC/HALT/FAULT);
  - EBREAK = 32'h00100073;
  - default RESET_PC;
  - XLEN = 64.
  - The core's $finish check uses the same EBREAK constant.
- One sub-module, fetch_watchdog: a TIMEOUT counter with clear/enable inputs and an expired output.

## Test plan
- Reset then zero-wait memory returning addi,addi,ebreak -> imem_addr 80000000, 80000004, 80000008; three exec_en pulses 2 cycles apart; halt=1; retired=3; pc=80000008.
- Ack delayed 3 cycles and stall=1 for 2 cycles on the first inst -> imem_req/addr stable throughout; exec_en exactly once per instruction; retired unaffected by stall cycles.
- br_taken=1, br_target=80000100 -> next imem_addr 80000100. br_target=80000102 -> fault=1, pc held, imem_req stays 0.
- Never ack with TIMEOUT=16 -> fault rises after 16 FETCH cycles. Ack arriving on cycle 16 -> no fault, EXEC entered.
- rst low for one cycle in the middle of FETCH, and again after HALT -> all outputs at reset values; fetch restarts at RESET_PC.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC with a non-branch inst -> pc wraps to 0, no fault.
